dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Shares the single-port data RAM between NREQ requesters: matrix-processor cores and the host loader.
- Each requester presents a single-word read or write. The block picks one requester round-robin, drives the RAM strobes for one cycle, and returns a registered ack (and read data for reads).
- Sits between each core's DRAM_addr/DRAM_dataOut/memREAD/memWRITE outputs and the physical DRAM.
- The cores' control units stall on the missing ack.

Parameters:
WIDTH, 8, data and address width in bits
NREQ, 2, number of requesters (2..4)
GW, $clog2(NREQ) (min 1), grant index width, derived

Ports:
Clk  in  1  clock; all state changes on rising edge
Rst  in  1  synchronous reset, active-high
req_read  in  NREQ  per-requester read request, held until ack
req_write  in  NREQ  per-requester write request, held until ack
req_addr  in  NREQ*WIDTH  packed addresses, slice i = requester i
req_wdata  in  NREQ*WIDTH  packed write data
ack  out  NREQ  one-cycle completion pulse per requester (registered)
rdata  out  NREQ*WIDTH  per-requester read data, valid with ack, held until next read by that requester
DRAM_addr  out  WIDTH  RAM address
DRAM_dataOut  out  WIDTH  RAM write data
DRAM_dataIn  in  WIDTH  RAM read data; sync RAM, valid one cycle after memREAD
memREAD  out  1  RAM read strobe
memWRITE  out  1  RAM write strobe
grant_id  out  GW  index of the requester currently being served
busy  out  1  high in every state except IDLE
proto_err  out  1  sticky: read and write were requested together

Behaviour:
- Reset values:
  - state=IDLE; ack=0, rdata=0, grant_id=0.
  - memREAD=0, memWRITE=0, DRAM_addr=0, DRAM_dataOut=0.
  - proto_err=0; last-grant pointer=NREQ-1, so requester 0 wins first.
- Requester i is eligible when (req_read[i]|req_write[i]) & ~ack[i]. Masking ack stops re-granting a request still held in the ack cycle.
- States: IDLE, ACCESS, RLAT.
- IDLE:
  - If any requester is eligible, search from last+1 modulo NREQ.
  - First eligible index is registered into grant_id and last; next state is ACCESS.
  - Otherwise stay in IDLE.
- ACCESS (one cycle):
  - DRAM_addr and DRAM_dataOut are the granted requester's slices, muxed from live inputs that the requester holds stable.
  - memREAD=req_read[g]; memWRITE=req_write[g] & ~req_read[g].
  - Write: set ack[g] at the end of the cycle, go to IDLE.
  - Read: go to RLAT.
- RLAT: capture DRAM_dataIn into the rdata slice g, set ack[g], go to IDLE.
- Latency from a request seen in IDLE at cycle t0:
  - write: memWRITE at t1, ack at t2;
  - read: memREAD at t1, ack and rdata at t3.
- Back-to-back: a new grant may be made in the IDLE cycle that coincides with an ack. Throughput is one write per 2 cycles or one read per 3.
- Fairness: with all requesters busy, each is served at least once per NREQ grants. Any request waits at most NREQ-1 other accesses.
- req_read and req_write both high for the granted requester: the read is performed and proto_err is set. proto_err clears only on Rst.
- A request withdrawn before its grant is ignored. Withdrawal after grant (during ACCESS or RLAT) is a protocol violation: the access completes on the last sampled strobes, with no other guarantee.
- memREAD and memWRITE are decoded from state. Both are 0 outside ACCESS, and they are never high together.
- Rst mid-operation:
  - Immediate return to the reset values above; a pending read ack is lost.
  - A write whose ACCESS cycle was already on the bus is committed to RAM; the requester must retry after reset.

Decomposition:
- Shared package/include (proc_param): state encodings ARB_IDLE/ARB_ACCESS/ARB_RLAT, default NREQ.
- Sub-module rr_picker: combinational round-robin priority encoder. Inputs are the eligible mask and last; outputs are found and index. It is reusable for future core-level schedulers.

Test Plan:
1. Rst, then requester 0 writes addr 0x10 data 0xA5 → memWRITE at t1 with DRAM_addr=0x10, DRAM_dataOut=0xA5; ack[0] at t2 only; busy high at t1 only.
2. Requester 1 reads 0x10 after test 1, RAM model returns 0xA5 → memREAD at t1; ack[1] and rdata[1]=0xA5 at t3; rdata[1] still 0xA5 ten cycles later.
3. Both requesters issue continuous writes for 8 grants → grant_id alternates 0,1,0,1…; each receives exactly 4 acks; memREAD and memWRITE never high together.
4. Requester 0 holds its request one cycle past ack → no duplicate grant; second access only when the request is re-asserted after a low cycle.
5. Requester 1 asserts req_read and req_write together at addr 0x22 → read performed, memWRITE stays 0, proto_err=1 and stays 1 until Rst.
6. Rst asserted during RLAT of a read → next cycle state IDLE, ack=0, memREAD=0, proto_err=0; re-issued read completes normally with 3-cycle latency.

Source files
------------

// File: rtl/proc_param.sv
// -----------------------------------------------------------------------------
// proc_param
//   Shared definitions for the matrix-processor memory subsystem: arbiter
//   state encoding, default requester count and the grant-index width helper.
// -----------------------------------------------------------------------------
package proc_param;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RLAT   = 2'd2
  } arb_state_t;

  localparam int DEFAULT_NREQ = 2;

  // Index width for n requesters; never narrower than one bit.
  function automatic int grant_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin priority encoder. Searches the eligible mask
//   starting at i_last+1 (mod N) and returns the first set index.
// Ports:
//   i_eligible  N   request mask
//   i_last      GW  index served most recently
//   o_found     1   at least one bit of i_eligible is set
//   o_index     GW  winning index (0 when o_found is low)
// -----------------------------------------------------------------------------
module rr_picker
  import proc_param::*;
#(
  parameter int N  = DEFAULT_NREQ,
  parameter int GW = grant_width(N)
) (
  input  logic [N-1:0]  i_eligible,
  input  logic [GW-1:0] i_last,
  output logic          o_found,
  output logic [GW-1:0] o_index
);

  int w_best;
  int w_dist;

  // Each candidate gets its distance from i_last+1 around the ring; the
  // eligible candidate with the smallest distance wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    o_found = 1'b0;
    o_index = '0;
    w_best  = N;
    w_dist  = 0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j + N - int'(i_last) - 1) % N;
      if (i_eligible[j] && (w_dist < w_best)) begin
        w_best  = w_dist;
        o_found = 1'b1;
        o_index = GW'(j);
      end
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// -----------------------------------------------------------------------------
// dram_arbiter
//   Shares one single-port synchronous data RAM between NREQ requesters.
//   One request is granted round-robin per access; writes take two cycles
//   (ACCESS, then ack), reads three (ACCESS, RLAT, then ack with data).
// Ports:
//   Clk, Rst          clock, synchronous active-high reset
//   req_read/write    NREQ        per-requester strobes, held until ack
//   req_addr/wdata    NREQ*WIDTH  packed per-requester address / write data
//   ack               NREQ        registered one-cycle completion pulse
//   rdata             NREQ*WIDTH  per-requester read data, held until next read
//   DRAM_addr/dataOut WIDTH       RAM address / write data (zero outside ACCESS)
//   DRAM_dataIn       WIDTH       RAM read data, one cycle after memREAD
//   memREAD/memWRITE  1           RAM strobes, only in ACCESS, mutually exclusive
//   grant_id          GW          requester currently being served
//   busy              1           state is not IDLE
//   proto_err         1           sticky: read and write requested together
// -----------------------------------------------------------------------------
module dram_arbiter
  import proc_param::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = DEFAULT_NREQ,
  parameter int GW    = grant_width(NREQ)
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [NREQ-1:0]       req_read,
  input  logic [NREQ-1:0]       req_write,
  input  logic [NREQ*WIDTH-1:0] req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ*WIDTH-1:0] rdata,
  output logic [WIDTH-1:0]      DRAM_addr,
  output logic [WIDTH-1:0]      DRAM_dataOut,
  input  logic [WIDTH-1:0]      DRAM_dataIn,
  output logic                  memREAD,
  output logic                  memWRITE,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic                  proto_err
);

  arb_state_t              r_state;
  logic [GW-1:0]           r_grant;
  logic [GW-1:0]           r_last;
  logic [NREQ-1:0]         r_ack;
  logic [NREQ*WIDTH-1:0]   r_rdata;
  logic                    r_proto_err;

  logic [NREQ-1:0]         w_eligible;
  logic                    w_found;
  logic [GW-1:0]           w_pick;
  logic [NREQ-1:0]         w_grant_oh;
  logic                    w_g_read;
  logic                    w_g_write;
  logic [WIDTH-1:0]        w_g_addr;
  logic [WIDTH-1:0]        w_g_wdata;
  logic                    w_access;

  // A request still held during its own ack cycle must not win again.
  assign w_eligible = (req_read | req_write) & ~r_ack;

  rr_picker #(
    .N  (NREQ),
    .GW (GW)
  ) u_picker (
    .i_eligible (w_eligible),
    .i_last     (r_last),
    .o_found    (w_found),
    .o_index    (w_pick)
  );

  // Select the granted requester's live strobes and slices.
  always_comb begin
    w_grant_oh = '0;
    w_g_read   = 1'b0;
    w_g_write  = 1'b0;
    w_g_addr   = '0;
    w_g_wdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant == GW'(i)) begin
        w_grant_oh[i] = 1'b1;
        w_g_read      = req_read[i];
        w_g_write     = req_write[i];
        w_g_addr      = req_addr[i*WIDTH +: WIDTH];
        w_g_wdata     = req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // RAM strobes are decoded from state; a simultaneous read wins over write.
  assign w_access     = (r_state == ARB_ACCESS);
  assign memREAD      = w_access & w_g_read;
  assign memWRITE     = w_access & w_g_write & ~w_g_read;
  assign DRAM_addr    = w_access ? w_g_addr  : '0;
  assign DRAM_dataOut = w_access ? w_g_wdata : '0;

  always_ff @(posedge Clk) begin
    // NOTE: all state uses non-blocking assignment so every register sees the
    // pre-edge values of the others, independent of statement order.
    if (Rst) begin
      r_state     <= ARB_IDLE;
      r_grant     <= '0;
      r_last      <= GW'(NREQ - 1);
      r_ack       <= '0;
      // NOTE: the rdata bank is a visible output register, not a RAM, so it is
      // cleared on reset like the rest of the state.
      r_rdata     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_state <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (w_g_read) begin
            if (w_g_write) r_proto_err <= 1'b1;
            r_state <= ARB_RLAT;
          end else begin
            // Write (or a withdrawn request): complete now.
            r_ack   <= w_grant_oh;
            r_state <= ARB_IDLE;
          end
        end
        ARB_RLAT: begin
          for (int i = 0; i < NREQ; i++) begin
            if (w_grant_oh[i]) r_rdata[i*WIDTH +: WIDTH] <= DRAM_dataIn;
          end
          r_ack   <= w_grant_oh;
          r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign grant_id  = r_grant;
  assign busy      = (r_state != ARB_IDLE);
  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_dram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dram_arbiter
//   Self-checking bench: directed latency/fairness scenarios followed by a
//   randomized phase. Expected acks and read data are queued per requester
//   when a request is issued and popped by an independent monitor on ack.
// -----------------------------------------------------------------------------
module tb_dram_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 2;
  localparam int GW    = 1;
  localparam int OPS   = 150;

  logic                  Clk = 1'b0;
  logic                  Rst = 1'b1;
  logic [NREQ-1:0]       req_read  = '0;
  logic [NREQ-1:0]       req_write = '0;
  logic [NREQ*WIDTH-1:0] req_addr  = '0;
  logic [NREQ*WIDTH-1:0] req_wdata = '0;
  logic [NREQ-1:0]       ack;
  logic [NREQ*WIDTH-1:0] rdata;
  logic [WIDTH-1:0]      DRAM_addr;
  logic [WIDTH-1:0]      DRAM_dataOut;
  logic [WIDTH-1:0]      DRAM_dataIn;
  logic                  memREAD;
  logic                  memWRITE;
  logic [GW-1:0]         grant_id;
  logic                  busy;
  logic                  proto_err;

  dram_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .req_read     (req_read),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .ack          (ack),
    .rdata        (rdata),
    .DRAM_addr    (DRAM_addr),
    .DRAM_dataOut (DRAM_dataOut),
    .DRAM_dataIn  (DRAM_dataIn),
    .memREAD      (memREAD),
    .memWRITE     (memWRITE),
    .grant_id     (grant_id),
    .busy         (busy),
    .proto_err    (proto_err)
  );

  always #5 Clk = ~Clk;

  // Synchronous single-port RAM behind the arbiter.
  bit [7:0] ram [256];
  always @(posedge Clk) begin
    if (memWRITE) ram[DRAM_addr] <= DRAM_dataOut;
    if (memREAD)  DRAM_dataIn    <= ram[DRAM_addr];
  end

  // Reference: what memory should hold, updated as writes are issued.
  bit [7:0] model_mem [256];

  typedef struct {
    bit         is_read;
    logic [7:0] data;
  } exp_t;
  exp_t sb_q [NREQ][$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a request and queue its expected outcome. A read (even one that
  // also asserts write) returns current memory; only a pure write changes it.
  task automatic drive(input int i, input bit rd, input bit wr,
                       input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    req_read[i]                 = rd;
    req_write[i]                = wr;
    req_addr[i*WIDTH +: WIDTH]  = a;
    req_wdata[i*WIDTH +: WIDTH] = d;
    e.is_read = rd;
    e.data    = rd ? model_mem[a] : 8'h00;
    sb_q[i].push_back(e);
    if (wr && !rd) model_mem[a] = d;
  endtask

  task automatic drop(input int i);
    req_read[i]  = 1'b0;
    req_write[i] = 1'b0;
  endtask

  task automatic do_op(input int i, input bit rd, input bit wr,
                       input logic [7:0] a, input logic [7:0] d);
    bit got;
    got = 1'b0;
    drive(i, rd, wr, a, d);
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge Clk);
      if (ack[i]) got = 1'b1;
    end
    drop(i);
    check("op_ack", 32'(got), 1);
  endtask

  // Monitor: strobe invariants every cycle, scoreboard pop on every ack.
  always @(negedge Clk) begin
    exp_t e;
    check("strobe_excl", 32'(memREAD & memWRITE), 0);
    check("strobe_outside_busy", 32'((memREAD | memWRITE) & ~busy), 0);
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i]) begin
        check($sformatf("ack%0d_expected", i), 32'(sb_q[i].size() > 0), 1);
        if (sb_q[i].size() > 0) begin
          e = sb_q[i].pop_front();
          if (e.is_read) check($sformatf("rdata%0d", i), 32'(rdata[i*WIDTH +: WIDTH]), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int         exp_g;
    int         g3;
    int         a3 [NREQ];
    bit         pend [NREQ];
    bit         granted [NREQ];
    int         others [NREQ];
    int         gap [NREQ];
    int         waitc [NREQ];
    int         done [NREQ];
    bit         rd;

    // Reset values
    repeat (3) @(negedge Clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_rdata", 32'(rdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_strobes", 32'({memREAD, memWRITE}), 0);
    check("rst_addr", 32'(DRAM_addr), 0);
    check("rst_dout", 32'(DRAM_dataOut), 0);
    check("rst_grant", 32'(grant_id), 0);
    check("rst_proto", 32'(proto_err), 0);
    Rst = 1'b0;
    @(negedge Clk);

    // 1: write from requester 0
    check("t1_busy_t0", 32'(busy), 0);
    drive(0, 0, 1, 8'h10, 8'hA5);
    @(negedge Clk);
    check("t1_memwrite_t1", 32'(memWRITE), 1);
    check("t1_memread_t1", 32'(memREAD), 0);
    check("t1_addr", 32'(DRAM_addr), 32'h10);
    check("t1_dout", 32'(DRAM_dataOut), 32'hA5);
    check("t1_busy_t1", 32'(busy), 1);
    check("t1_grant", 32'(grant_id), 0);
    check("t1_ack_t1", 32'(ack), 0);
    @(negedge Clk);
    check("t1_ack_t2", 32'(ack), 32'b01);
    check("t1_busy_t2", 32'(busy), 0);
    drop(0);
    @(negedge Clk);
    check("t1_ack_t3", 32'(ack), 0);

    // 2: read back from requester 1
    drive(1, 1, 0, 8'h10, 8'h00);
    @(negedge Clk);
    check("t2_memread_t1", 32'(memREAD), 1);
    check("t2_memwrite_t1", 32'(memWRITE), 0);
    check("t2_addr", 32'(DRAM_addr), 32'h10);
    check("t2_grant", 32'(grant_id), 1);
    @(negedge Clk);
    check("t2_ack_t2", 32'(ack), 0);
    check("t2_busy_t2", 32'(busy), 1);
    @(negedge Clk);
    check("t2_ack_t3", 32'(ack), 32'b10);
    check("t2_rdata_t3", 32'(rdata[15:8]), 32'hA5);
    drop(1);
    repeat (10) @(negedge Clk);
    check("t2_rdata_held", 32'(rdata[15:8]), 32'hA5);

    // 3: both requesters stream writes; last grant was 1, so 0 goes first
    exp_g = 0;
    g3    = 0;
    a3    = '{default: 0};
    for (int i = 0; i < NREQ; i++) drive(i, 0, 1, 8'(8'h30 + i), 8'($urandom));
    for (int c = 0; c < 40 && (a3[0] < 4 || a3[1] < 4); c++) begin
      @(negedge Clk);
      if (memWRITE) begin
        check("t3_grant_order", 32'(grant_id), 32'(exp_g));
        check("t3_dout", 32'(DRAM_dataOut), 32'(req_wdata[exp_g*WIDTH +: WIDTH]));
        exp_g = 1 - exp_g;
        g3++;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (ack[i]) begin
          a3[i]++;
          if (a3[i] < 4) drive(i, 0, 1, 8'(8'h30 + i), 8'($urandom));
          else drop(i);
        end
      end
    end
    check("t3_acks0", 32'(a3[0]), 4);
    check("t3_acks1", 32'(a3[1]), 4);
    check("t3_grants", 32'(g3), 8);
    repeat (2) @(negedge Clk);

    // 4: request held through its ack edge must not be re-granted
    drive(0, 0, 1, 8'h11, 8'h3C);
    @(negedge Clk);
    check("t4_first_write", 32'(memWRITE), 1);
    @(negedge Clk);
    check("t4_first_ack", 32'(ack), 32'b01);
    @(posedge Clk);
    #1 drop(0);
    @(negedge Clk);
    check("t4_no_dup_t3", 32'(busy), 0);
    @(negedge Clk);
    check("t4_no_dup_t4", 32'(busy), 0);
    drive(0, 0, 1, 8'h11, 8'hC3);
    @(negedge Clk);
    check("t4_second_write", 32'(memWRITE), 1);
    check("t4_second_dout", 32'(DRAM_dataOut), 32'hC3);
    @(negedge Clk);
    check("t4_second_ack", 32'(ack), 32'b01);
    drop(0);
    @(negedge Clk);

    // 5: read and write together from requester 1
    d = 8'($urandom_range(1, 254));
    do_op(0, 0, 1, 8'h22, d);
    @(negedge Clk);
    check("t5_proto_before", 32'(proto_err), 0);
    drive(1, 1, 1, 8'h22, ~d);
    @(negedge Clk);
    check("t5_memread", 32'(memREAD), 1);
    check("t5_memwrite", 32'(memWRITE), 0);
    check("t5_addr", 32'(DRAM_addr), 32'h22);
    @(negedge Clk);
    check("t5_proto_set", 32'(proto_err), 1);
    @(negedge Clk);
    check("t5_ack", 32'(ack), 32'b10);
    check("t5_rdata", 32'(rdata[15:8]), 32'(d));
    drop(1);
    repeat (5) @(negedge Clk);
    check("t5_proto_sticky", 32'(proto_err), 1);
    check("t5_ram_unchanged", 32'(ram[8'h22]), 32'(d));
    do_op(0, 1, 0, 8'h22, 8'h00);
    @(negedge Clk);

    // 6: reset during RLAT
    drive(0, 1, 0, 8'h10, 8'h00);
    @(negedge Clk);
    check("t6_memread", 32'(memREAD), 1);
    @(negedge Clk);
    check("t6_rlat_busy", 32'(busy), 1);
    Rst = 1'b1;
    drop(0);
    @(negedge Clk);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_ack", 32'(ack), 0);
    check("t6_rst_memread", 32'(memREAD), 0);
    check("t6_rst_proto", 32'(proto_err), 0);
    check("t6_rst_rdata", 32'(rdata), 0);
    check("t6_rst_grant", 32'(grant_id), 0);
    Rst = 1'b0;
    for (int i = 0; i < NREQ; i++) sb_q[i].delete();
    @(negedge Clk);
    drive(0, 1, 0, 8'h10, 8'h00);
    @(negedge Clk);
    check("t6_retry_memread", 32'(memREAD), 1);
    check("t6_retry_grant", 32'(grant_id), 0);
    @(negedge Clk);
    check("t6_retry_ack_t2", 32'(ack), 0);
    @(negedge Clk);
    check("t6_retry_ack_t3", 32'(ack), 32'b01);
    check("t6_retry_rdata", 32'(rdata[7:0]), 32'hA5);
    drop(0);
    @(negedge Clk);

    // Random phase: each requester works in its own address window
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; granted[i] = 1'b0; others[i] = 0;
      gap[i] = 0; waitc[i] = 0; done[i] = 0;
    end
    for (int cyc = 0; cyc < 4000 && (done[0] < OPS || done[1] < OPS); cyc++) begin
      @(negedge Clk);
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i]) begin
          waitc[i]++;
          if (memREAD | memWRITE) begin
            if (int'(grant_id) == i) granted[i] = 1'b1;
            else if (!granted[i]) others[i]++;
          end
          if (ack[i]) begin
            check("rand_fair_wait", 32'(others[i] <= NREQ - 1), 1);
            drop(i);
            pend[i] = 1'b0;
            gap[i]  = $urandom_range(0, 3);
            done[i]++;
          end else if (waitc[i] > 20) begin
            check("rand_ack_timeout", 32'(waitc[i]), 20);
            drop(i);
            sb_q[i].delete();
            pend[i] = 1'b0;
            done[i]++;
          end
        end else if (gap[i] > 0) begin
          gap[i]--;
        end else if (done[i] < OPS) begin
          rd = 1'($urandom_range(0, 1));
          drive(i, rd, !rd, 8'(64 * (i + 1) + $urandom_range(0, 63)), 8'($urandom));
          pend[i] = 1'b1; granted[i] = 1'b0; others[i] = 0; waitc[i] = 0;
        end
      end
    end
    check("rand_done0", 32'(done[0]), OPS);
    check("rand_done1", 32'(done[1]), OPS);

    repeat (5) @(negedge Clk);
    for (int i = 0; i < NREQ; i++) check($sformatf("sb_empty%0d", i), 32'(sb_q[i].size()), 0);
    check("final_proto", 32'(proto_err), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
